mul_div_unit: RTL

Parametrised iterative multiply/divide unit that carries the ALU's MULT/MULTU and DIV/DIVU operation codes into a multi-cycle datapath with architectural HI/LO registers. It sits beside the combinational ALU in the execute stage. A start/busy/done handshake lets the pipeline stall while it runs. MTHI/MTLO writes and an exception-flush cancel are supported.

---
 rtl/mul_div_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// Handles MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring division),
// taking one iteration per cycle for WIDTH cycles. A result is written to HI/LO
// one cycle after the last iteration, and done pulses in the following cycle.
// Signed operations run on operand magnitudes, with the sign fixed up at the end.
// MTHI/MTLO writes are accepted only while idle. cancel aborts an operation in
// flight.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   operation request, sampled only in IDLE
//   op      5'b10010 MULT, 5'b10011 MULTU, 5'b10100 DIV, 5'b10101 DIVU
//   a, b    multiplicand/dividend (rs), multiplier/divisor (rt)
//   cancel  flush; aborts an in-flight operation
//   hi_we   MTHI write enable (IDLE only)
//   lo_we   MTLO write enable (IDLE only)
//   wdata   MTHI/MTLO data
//   busy    high while not idle
//   done    one-cycle pulse; hi/lo hold the new result
//   div0    pulses with done when a divide had b == 0
//   hi, lo  HI and LO registers
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // mul: {partial, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]     mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 b_zero_q, b_zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, div0_q, div0_d;

  // Operation decode
  logic op_valid, op_signed, op_div;
  assign op_valid  = (op == 5'b10010) || (op == 5'b10011) ||
                     (op == 5'b10100) || (op == 5'b10101);
  assign op_signed = ~op[0];
  assign op_div    = op[2];

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

  // Multiply step: conditionally add the multiplicand to the upper half, then shift right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

  // Restoring divide step: shift the next dividend bit into the remainder, then trial-subtract.
  logic [WIDTH:0] rem_shift, rem_diff;
  assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, mcand_q};

  // Final sign correction
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod    = neg_res_q ? -acc_q : acc_q;
  assign quo_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && op_valid && !cancel) begin
          state_d   = StCalc;
          cnt_d     = '0;
          is_div_d  = op_div;
          b_zero_d  = (b == '0);
          neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = op_signed && a[WIDTH-1];
          if (op_div) begin
            mcand_d = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
          end else begin
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      StCalc: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            if (!rem_diff[WIDTH]) begin
              acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero: quotient all ones; the sign-fixed remainder equals raw a.
            lo_d   = b_zero_q ? {WIDTH{1'b1}} : quo_fix;
            hi_d   = rem_fix;
            div0_d = b_zero_q;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
